// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART byte transmitter.
// Ownership is held for a whole line (up to EOL_BYTE) and alternates round-robin between lines.
module uart_tx_arbiter #(
  parameter logic [7:0] EOL_BYTE     = 8'h0A,
  parameter int         LOCK_TIMEOUT = 1_000_000,
  parameter int         TMR_W        = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_start_tx,
  input  logic [7:0] req0_tx_din,
  output logic       req0_tx_done,
  input  logic       req1_start_tx,
  input  logic [7:0] req1_tx_din,
  output logic       req1_tx_done,
  output logic       uart_start_tx,
  output logic [7:0] uart_tx_din,
  input  logic       uart_tx_done,
  output logic [1:0] owner,
  output logic       overflow_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic             own;
  logic             own_next;
  logic             last_owner;
  logic             release_line;
  logic [TMR_W-1:0] timer;
  logic [1:0]       pend_valid;
  logic [7:0]       pend_data [2];
  logic [7:0]       din_in [2];
  logic [1:0]       start_in;
  logic             is_eol;
  logic             done_q;
  logic             done_rise;

  logic             start_d;
  logic [1:0]       owner_d;
  logic [1:0]       done_d;
  logic [1:0]       clear_slot;
  logic [1:0]       accept;
  logic             ovf_set;

  assign start_in  = {req1_start_tx, req0_start_tx};
  assign din_in[0] = req0_tx_din;
  assign din_in[1] = req1_tx_din;
  assign done_rise = uart_tx_done & ~done_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      own   <= 1'b0;
    end else begin
      state <= next_state;
      own   <= own_next;
    end
  end

  // Next-state logic; release_line marks the cycles that hand the line back
  always_comb begin
    next_state   = state;
    own_next     = own;
    release_line = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid != 2'b00) begin
          next_state = ISSUE;
          own_next   = (pend_valid == 2'b11) ? ~last_owner : pend_valid[1];
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: next_state = BUSY;
      BUSY: begin
        if (done_rise) begin
          next_state   = is_eol ? IDLE : HOLD;
          release_line = is_eol;
        end else begin
          next_state = BUSY;
        end
      end
      HOLD: begin
        if (pend_valid[own]) begin
          next_state = ISSUE;
        end else if (timer == TMR_LAST) begin
          next_state   = IDLE;
          release_line = 1'b1;
        end else begin
          next_state = HOLD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and of the pending slots
  always_comb begin
    start_d    = (next_state == ISSUE);
    owner_d    = (next_state == IDLE) ? 2'b00 : (own_next ? 2'b10 : 2'b01);
    done_d     = ((state == BUSY) && done_rise) ? (own ? 2'b10 : 2'b01) : 2'b00;
    clear_slot = (state == ISSUE) ? (own ? 2'b10 : 2'b01) : 2'b00;
    // a start landing on the cycle its slot empties is accepted, not an overflow
    accept     = start_in & (~pend_valid | clear_slot);
    ovf_set    = |(start_in & pend_valid & ~clear_slot);
  end

  // Datapath, pending slots and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner    <= 1'b1;
      timer         <= '0;
      pend_valid    <= 2'b00;
      pend_data[0]  <= 8'h00;
      pend_data[1]  <= 8'h00;
      is_eol        <= 1'b0;
      done_q        <= 1'b0;
      uart_start_tx <= 1'b0;
      uart_tx_din   <= 8'h00;
      owner         <= 2'b00;
      req0_tx_done  <= 1'b0;
      req1_tx_done  <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      done_q <= uart_tx_done;
      if (release_line) begin
        last_owner <= own;
      end
      timer <= (state == HOLD) ? timer + TMR_W'(1) : '0;
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          pend_valid[i] <= 1'b1;
          pend_data[i]  <= din_in[i];
        end else if (clear_slot[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
      // din is loaded together with the start pulse so the UART sees both at once
      if (next_state == ISSUE) begin
        uart_tx_din <= pend_data[own_next];
        is_eol      <= (pend_data[own_next] == EOL_BYTE);
      end
      uart_start_tx <= start_d;
      owner         <= owner_d;
      req0_tx_done  <= done_d[0];
      req1_tx_done  <= done_d[1];
      if (ovf_set) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural line-ownership model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_start_tx = 1'b0;
  logic [7:0] req0_tx_din = 8'h00;
  logic       req0_tx_done;
  logic       req1_start_tx = 1'b0;
  logic [7:0] req1_tx_din = 8'h00;
  logic       req1_tx_done;
  logic       uart_start_tx;
  logic [7:0] uart_tx_din;
  logic       uart_tx_done = 1'b0;
  logic [1:0] owner;
  logic       overflow_err;

  uart_tx_arbiter #(.EOL_BYTE(8'h0A), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .req0_start_tx(req0_start_tx), .req0_tx_din(req0_tx_din), .req0_tx_done(req0_tx_done),
    .req1_start_tx(req1_start_tx), .req1_tx_din(req1_tx_din), .req1_tx_done(req1_tx_done),
    .uart_start_tx(uart_start_tx), .uart_tx_din(uart_tx_din), .uart_tx_done(uart_tx_done),
    .owner(owner), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots hold at most one waiting byte; cur is the line owner (0 none, 1 req0, 2 req1);
  // a byte is announced one cycle (issue) then in flight until a done edge.
  bit         m_sv [2];
  logic [7:0] m_sd [2];
  int         m_cur, m_last, m_hold;
  bit         m_issue, m_fly, m_eol, m_dprev;
  logic       e_start = 1'b0, e_d0 = 1'b0, e_d1 = 1'b0, e_ovf = 1'b0;
  logic [7:0] e_din = 8'h00;
  logic [1:0] e_owner = 2'b00;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_sv[0] = 0; m_sv[1] = 0; m_sd[0] = 8'h00; m_sd[1] = 8'h00;
      m_cur = 0; m_last = 2; m_hold = 0; m_issue = 0; m_fly = 0; m_eol = 0; m_dprev = 0;
      e_start = 0; e_d0 = 0; e_d1 = 0; e_ovf = 0; e_din = 8'h00; e_owner = 2'b00;
    end else begin
      bit rise, n_start;
      bit st [2];
      logic [7:0] dn [2];
      int clr;
      st[0] = req0_start_tx; st[1] = req1_start_tx;
      dn[0] = req0_tx_din;   dn[1] = req1_tx_din;
      rise = uart_tx_done && !m_dprev;
      m_dprev = uart_tx_done;
      n_start = 0; clr = 0; e_d0 = 0; e_d1 = 0;
      if (m_issue) begin
        m_issue = 0; m_fly = 1; clr = m_cur;
      end else if (m_fly) begin
        if (rise) begin
          if (m_cur == 1) e_d0 = 1; else e_d1 = 1;
          m_fly = 0;
          if (m_eol) begin m_last = m_cur; m_cur = 0; end
          else m_hold = 0;
        end
      end else if (m_cur != 0) begin
        if (m_sv[m_cur-1]) n_start = 1;
        else if (m_hold == LT - 1) begin m_last = m_cur; m_cur = 0; end
        else m_hold++;
      end else if (m_sv[0] || m_sv[1]) begin
        m_cur = (m_sv[0] && m_sv[1]) ? 3 - m_last : (m_sv[0] ? 1 : 2);
        n_start = 1;
      end
      if (n_start) begin
        m_issue = 1;
        e_din = m_sd[m_cur-1];
        m_eol = (e_din == 8'h0A);
      end
      for (int i = 0; i < 2; i++) begin
        if (st[i]) begin
          if (m_sv[i] && clr != i + 1) e_ovf = 1;
          else begin m_sv[i] = 1; m_sd[i] = dn[i]; end
        end else if (clr == i + 1) begin
          m_sv[i] = 0;
        end
      end
      e_start = n_start;
      e_owner = 2'(m_cur);
    end
  end

  // Compare DUT against the model every cycle once reset has been applied
  always @(negedge clk) begin
    if (armed) begin
      chk("uart_start_tx", uart_start_tx, e_start);
      chk("uart_tx_din", uart_tx_din, e_din);
      chk("req0_tx_done", req0_tx_done, e_d0);
      chk("req1_tx_done", req1_tx_done, e_d1);
      chk("owner", owner, e_owner);
      chk("overflow_err", overflow_err, e_ovf);
    end
  end

  // ---------------- logging and UART responder ----------------
  logic [7:0] ulog [$];
  logic [1:0] olog [$];
  int         scyc [$];
  int         srise [$];
  int         d0cnt = 0, d1cnt = 0, last_rise = 0;
  bit         uart_auto = 1'b1;
  int         u_wait = 0, u_hi = 0, u_hold = 2, hold_fix = 0;

  always @(negedge clk) begin
    if (uart_start_tx) begin
      ulog.push_back(uart_tx_din); olog.push_back(owner);
      scyc.push_back(cyc); srise.push_back(last_rise);
    end
    if (req0_tx_done) d0cnt++;
    if (req1_tx_done) d1cnt++;
    if (uart_auto) begin
      if (u_hi > 0) begin
        if (!uart_tx_done) last_rise = cyc;
        uart_tx_done = 1'b1; u_hi--;
      end else begin
        uart_tx_done = 1'b0;
        if (u_wait > 0) begin u_wait--; if (u_wait == 0) u_hi = u_hold; end
      end
      if (uart_start_tx) begin
        u_wait = $urandom_range(2, 5);
        u_hold = (hold_fix != 0) ? hold_fix : $urandom_range(1, 3);
      end
    end
  end

  function automatic logic [7:0] ubyte(input int i);
    if (i < ulog.size()) return ulog[i];
    return 8'hxx;
  endfunction

  function automatic logic [1:0] uown(input int i);
    if (i < olog.size()) return olog[i];
    return 2'bxx;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input int r, input logic [7:0] b);
    @(negedge clk);
    if (r == 0) begin req0_start_tx = 1'b1; req0_tx_din = b; end
    else begin req1_start_tx = 1'b1; req1_tx_din = b; end
    @(negedge clk);
    req0_start_tx = 1'b0; req1_start_tx = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    req0_start_tx = 1'b1; req0_tx_din = b0;
    req1_start_tx = 1'b1; req1_tx_din = b1;
    @(negedge clk);
    req0_start_tx = 1'b0; req1_start_tx = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (ulog.size() < n && k < 200) begin @(negedge clk); k++; end
    chk("wait_uart_start", 32'(ulog.size() >= n), 32'd1);
  endtask

  task automatic wait_d0(input int n);
    int k = 0;
    while (d0cnt < n && k < 200) begin @(negedge clk); k++; end
    chk("wait_req0_done", 32'(d0cnt >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); armed = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int b, n0, n1;
    do_reset();
    chk("reset_owner", owner, 2'b00);
    chk("reset_ovf", overflow_err, 1'b0);
    chk("reset_start", uart_start_tx, 1'b0);

    // single requester line, done held two cycles
    hold_fix = 2;
    b = ulog.size(); n0 = d0cnt;
    send(0, 8'h41); wait_d0(n0 + 1);
    send(0, 8'h42); wait_d0(n0 + 2);
    send(0, 8'h0A); wait_d0(n0 + 3);
    repeat (3) @(negedge clk);
    chk("t1_byte0", ubyte(b), 8'h41);
    chk("t1_byte1", ubyte(b + 1), 8'h42);
    chk("t1_byte2", ubyte(b + 2), 8'h0A);
    chk("t1_done_pulses", 32'(d0cnt - n0), 32'd3);
    chk("t1_owner_released", owner, 2'b00);
    hold_fix = 0;

    // contention right after reset: req0 wins, req1 waits for the end of the line
    do_reset();
    b = ulog.size();
    send2(8'h55, 8'hAA);
    wait_log(b + 1);
    send(0, 8'h0A);
    wait_log(b + 3);
    send(1, 8'h0A);
    wait_log(b + 4);
    repeat (10) @(negedge clk);
    chk("t2_first", ubyte(b), 8'h55);
    chk("t2_first_owner", uown(b), 2'b01);
    chk("t2_eol0", ubyte(b + 1), 8'h0A);
    chk("t2_req1", ubyte(b + 2), 8'hAA);
    chk("t2_req1_owner", uown(b + 2), 2'b10);

    // round robin with both requesters pending at every release
    b = ulog.size();
    send2(8'h0A, 8'h0A);
    for (int k = 0; k < 4; k++) begin
      wait_log(b + k + 1);
      if (k < 3) send((uown(b + k) == 2'b01) ? 0 : 1, 8'h0A);
    end
    wait_log(b + 5);
    repeat (10) @(negedge clk);
    chk("t3_rr0", uown(b), 2'b01);
    chk("t3_rr1", uown(b + 1), 2'b10);
    chk("t3_rr2", uown(b + 2), 2'b01);
    chk("t3_rr3", uown(b + 3), 2'b10);

    // lock timeout: release 16 HOLD cycles after the done edge, next start two cycles later
    b = ulog.size();
    send(0, 8'h31);
    wait_log(b + 1);
    send(1, 8'h32);
    wait_log(b + 2);
    chk("t4_byte", ubyte(b + 1), 8'h32);
    chk("t4_owner", uown(b + 1), 2'b10);
    if (scyc.size() > b + 1) chk("t4_latency", 32'(scyc[b+1] - srise[b+1]), 32'd18);
    else chk("t4_latency_missing", 32'(scyc.size()), 32'(b + 2));
    send(1, 8'h0A);
    wait_log(b + 3);
    repeat (10) @(negedge clk);

    // overflow: second req1 byte is dropped, flag is sticky
    b = ulog.size();
    send(0, 8'h41);
    wait_log(b + 1);
    send(1, 8'h61);
    send(1, 8'h62);
    @(negedge clk);
    chk("t5_ovf_set", overflow_err, 1'b1);
    send(0, 8'h0A);
    wait_log(b + 3);
    send(1, 8'h0A);
    wait_log(b + 4);
    repeat (20) @(negedge clk);
    chk("t5_eol0", ubyte(b + 1), 8'h0A);
    chk("t5_kept", ubyte(b + 2), 8'h61);
    chk("t5_dropped", 32'(ulog.size()), 32'(b + 4));
    chk("t5_ovf_sticky", overflow_err, 1'b1);

    // reset while a byte is in flight: the late done edge must be ignored
    uart_auto = 1'b0; uart_tx_done = 1'b0;
    do_reset();
    b = ulog.size();
    send(0, 8'h11);
    wait_log(b + 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n0 = d0cnt; n1 = d1cnt; b = ulog.size();
    @(negedge clk); uart_tx_done = 1'b1;
    repeat (2) @(negedge clk); uart_tx_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_done0", 32'(d0cnt - n0), 32'd0);
    chk("t6_no_done1", 32'(d1cnt - n1), 32'd0);
    chk("t6_no_start", 32'(ulog.size() - b), 32'd0);
    chk("t6_owner", owner, 2'b00);
    chk("t6_ovf", overflow_err, 1'b0);
    u_wait = 0; u_hi = 0;
    uart_auto = 1'b1;

    // randomized traffic, with the occasional reset
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      req0_start_tx = ($urandom_range(0, 5) == 0);
      req0_tx_din = ($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom);
      req1_start_tx = ($urandom_range(0, 5) == 0);
      req1_tx_din = ($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; req0_start_tx = 1'b0; req1_start_tx = 1'b0;
    repeat (150) @(negedge clk);
    chk("drain_owner", owner, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
